// File: rtl/jtframe_ba_responder.sv
// jtframe_ba_responder
// Single-bank responder for the jtframe bank request protocol, backed by a
// 2**AW x 16 internal memory. It reproduces the ack / dok / rdy timing a
// requester sees from the SDRAM controller.
//
// Handshake: rd or wr is held by the requester until ack. ack is a one-cycle
// pulse in the cycle after the sampling edge. Reads return W = LEN/16 words,
// one per cycle with dok, and rdy marks the last one. Writes return a single
// rdy pulse and never dok.
//
// Optional feature: define JTFRAME_BA_RESP_STALL_EN to add LFSR-driven random
// acceptance stalls in IDLE.
module jtframe_ba_responder #(
    parameter int    AW      = 10,
    parameter int    LEN     = 64,
    parameter int    LAT     = 3,
    parameter int    WRLAT   = 2,
    parameter string MEMFILE = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [21:0] ba_addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [15:0] din,
    input  logic [1:0]  din_m,
    output logic        ack,
    output logic        dok,
    output logic        rdy,
    output logic [15:0] dout,
    output logic        err
);

    localparam int W = LEN / 16;
    localparam logic [AW-1:0] BASE_MASK = ~(AW'(W - 1));
    localparam logic [1:0]    LAST_IDX  = 2'(W - 1);
    localparam logic [3:0]    RD_M1     = 4'(LAT - 1);
    localparam logic [3:0]    WR_M1     = 4'(WRLAT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACK   = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_BURST = 2'd3;

    logic [1:0]    state;
    logic          is_wr;
    logic [AW-1:0] base;
    logic [3:0]    cnt;
    logic [1:0]    idx;
    logic          wait_first;
    logic [15:0]   mem [2**AW];

    logic          can_take;
    logic          take;
    logic          drop_viol;
    logic          viol;
    logic [3:0]    lat_m1;
    logic [1:0]    idx_n;
    logic [AW-1:0] waddr;
    logic          unused_addr;

    assign unused_addr = ^ba_addr[21:AW];

`ifdef JTFRAME_BA_RESP_STALL_EN
    logic [7:0] lfsr;
    logic       pend;

    // Fibonacci LFSR (taps 8,6,5,4) free-running; decides acceptance in IDLE
    always_ff @(posedge clk) begin
        if (!rst_n) lfsr <= 8'h01;
        else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    // Remember a request that was seen but stalled, to catch early withdrawal
    always_ff @(posedge clk) begin
        if (!rst_n) pend <= 1'b0;
        else        pend <= (state == ST_IDLE) && (rd | wr) && !can_take;
    end

    assign can_take  = lfsr[2:0] != 3'd0;
    assign drop_viol = pend && (state == ST_IDLE) && !(rd | wr);
`else
    assign can_take  = 1'b1;
    assign drop_viol = 1'b0;
`endif

    assign take   = (state == ST_IDLE) && (rd | wr) && can_take;
    assign waddr  = ba_addr[AW-1:0];
    assign lat_m1 = is_wr ? WR_M1 : RD_M1;
    assign idx_n  = idx + 2'd1;
    assign viol   = ((state == ST_IDLE) && rd && wr)
                  || ((state == ST_WAIT) && !wait_first && (rd | wr))
                  || drop_viol;

    // Write commit with byte mask on the accepting edge; reset never touches memory
    always_ff @(posedge clk) begin
        if (rst_n && take && wr)
            mem[waddr] <= {din_m[1] ? mem[waddr][15:8] : din[15:8],
                           din_m[0] ? mem[waddr][7:0]  : din[7:0]};
    end

    // Request FSM: accept, latency count, burst output, sticky error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ack        <= 1'b0;
            dok        <= 1'b0;
            rdy        <= 1'b0;
            err        <= 1'b0;
            dout       <= 16'h0;
            cnt        <= 4'd0;
            idx        <= 2'd0;
            is_wr      <= 1'b0;
            base       <= '0;
            wait_first <= 1'b0;
        end else begin
            ack <= 1'b0;
            dok <= 1'b0;
            rdy <= 1'b0;
            if (viol) err <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        is_wr <= wr;
                        base  <= wr ? waddr : (waddr & BASE_MASK);
                        ack   <= 1'b1;
                        state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    wait_first <= 1'b1;
                    cnt        <= lat_m1;
                    // A latency of 1 leaves no WAIT cycle: respond right away
                    if (lat_m1 == 4'd0) begin
                        if (is_wr) begin
                            rdy   <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            dok   <= 1'b1;
                            dout  <= mem[base];
                            idx   <= 2'd0;
                            rdy   <= (LAST_IDX == 2'd0);
                            state <= ST_BURST;
                        end
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wait_first <= 1'b0;
                    cnt        <= cnt - 4'd1;
                    // Fire when the decremented count reaches zero so the
                    // registered pulse lands exactly LAT/WRLAT after ack
                    if (cnt == 4'd1) begin
                        if (is_wr) begin
                            rdy   <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            dok   <= 1'b1;
                            dout  <= mem[base];
                            idx   <= 2'd0;
                            rdy   <= (LAST_IDX == 2'd0);
                            state <= ST_BURST;
                        end
                    end
                end
                default: begin
                    if (idx == LAST_IDX) begin
                        state <= ST_IDLE;
                    end else begin
                        idx  <= idx_n;
                        dout <= mem[base + AW'(idx_n)];
                        dok  <= 1'b1;
                        rdy  <= (idx_n == LAST_IDX);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtframe_ba_responder.sv
// Bench for jtframe_ba_responder: three instances (LEN 64/32/16 with different
// latencies) driven one at a time and checked against a shadow memory model.
module tb_jtframe_ba_responder;

    localparam int ND = 3;
    localparam int MA = 64;

    logic clk = 1'b0;
    logic rst_n;
    logic [ND-1:0] rd, wr, ack, dok, rdy, err;
    logic [21:0]   addr  [ND];
    logic [15:0]   din   [ND];
    logic [15:0]   dout  [ND];
    logic [1:0]    din_m [ND];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [15:0] shadow    [ND][MA];
    logic [15:0] last_dout [ND];
    logic        exp_err   [ND];
    int          ack_cyc   [ND];
    int          rdy_cyc   [ND];

    // clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    generate
        for (genvar g = 0; g < ND; g++) begin : g_dut
            jtframe_ba_responder #(
                .AW(10),
                .LEN  ((g == 0) ? 64 : (g == 1) ? 32 : 16),
                .LAT  ((g == 0) ? 3  : (g == 1) ? 2  : 1),
                .WRLAT((g == 0) ? 2  : (g == 1) ? 3  : 1)
            ) u_dut (
                .clk(clk), .rst_n(rst_n), .ba_addr(addr[g]), .rd(rd[g]), .wr(wr[g]),
                .din(din[g]), .din_m(din_m[g]), .ack(ack[g]), .dok(dok[g]),
                .rdy(rdy[g]), .dout(dout[g]), .err(err[g])
            );
        end
    endgenerate

    function automatic int w_of(int d);     return (d == 0) ? 4 : (d == 1) ? 2 : 1; endfunction
    function automatic int lat_of(int d);   return (d == 0) ? 3 : (d == 1) ? 2 : 1; endfunction
    function automatic int wrlat_of(int d); return (d == 0) ? 2 : (d == 1) ? 3 : 1; endfunction

    // One complete transaction on instance d, checked cycle by cycle
    task automatic do_txn(input int d, input bit do_rd, input bit do_wr, input int a,
                          input logic [15:0] data, input logic [1:0] m);
        int wait_n;
        bit got;
        int base;
        int lt;
        int w;
        logic [15:0] old;
        addr[d]  = 22'(a);
        din[d]   = data;
        din_m[d] = m;
        rd[d]    = do_rd;
        wr[d]    = do_wr;
        got = 1'b0;
        wait_n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (ack[d]) begin got = 1'b1; wait_n = i; break; end
        end
        rd[d] = 1'b0;
        wr[d] = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout d%0d addr %0h got no ack want ack", d, a);
            return;
        end
        ack_cyc[d] = cyc;
        checks++;
`ifdef JTFRAME_BA_RESP_STALL_EN
        if (wait_n > 8) begin
            errors++;
            $display("FAIL ack_delay d%0d got %0d want <=8", d, wait_n);
        end
`else
        if (wait_n != 1) begin
            errors++;
            $display("FAIL ack_delay d%0d got %0d want 1", d, wait_n);
        end
`endif
        checks++;
        if ({dok[d], rdy[d]} !== 2'b00) begin
            errors++;
            $display("FAIL ack_cycle_pulses d%0d got dok,rdy=%b want 00", d, {dok[d], rdy[d]});
        end
        if (do_wr) begin
            old = shadow[d][a];
            shadow[d][a] = {m[1] ? old[15:8] : data[15:8], m[0] ? old[7:0] : data[7:0]};
            if (do_rd) exp_err[d] = 1'b1;
            lt = wrlat_of(d);
            for (int k = 1; k <= lt; k++) begin
                @(posedge clk); #1;
                checks++;
                if ({ack[d], dok[d], rdy[d]} !== {2'b00, (k == lt)}) begin
                    errors++;
                    $display("FAIL wr_pulses d%0d k%0d got ack,dok,rdy=%b want %b",
                             d, k, {ack[d], dok[d], rdy[d]}, {2'b00, (k == lt)});
                end
                checks++;
                if (dout[d] !== last_dout[d]) begin
                    errors++;
                    $display("FAIL dout_hold d%0d got %h want %h", d, dout[d], last_dout[d]);
                end
            end
        end else begin
            w = w_of(d);
            lt = lat_of(d);
            base = a - (a % w);
            for (int k = 1; k <= lt + w - 1; k++) begin
                @(posedge clk); #1;
                checks++;
                if ({ack[d], dok[d], rdy[d]} !== {1'b0, (k >= lt), (k == lt + w - 1)}) begin
                    errors++;
                    $display("FAIL rd_pulses d%0d k%0d got ack,dok,rdy=%b want %b", d, k,
                             {ack[d], dok[d], rdy[d]}, {1'b0, (k >= lt), (k == lt + w - 1)});
                end
                if (k >= lt) last_dout[d] = shadow[d][(base + k - lt) % MA];
                checks++;
                if (dout[d] !== last_dout[d]) begin
                    errors++;
                    $display("FAIL rd_data d%0d addr %0h k%0d got %h want %h",
                             d, a, k, dout[d], last_dout[d]);
                end
            end
        end
        rdy_cyc[d] = cyc;
        @(posedge clk); #1;
        checks++;
        if ({ack[d], dok[d], rdy[d]} !== 3'b000) begin
            errors++;
            $display("FAIL post_rdy d%0d got ack,dok,rdy=%b want 000", d, {ack[d], dok[d], rdy[d]});
        end
        checks++;
        if (err[d] !== exp_err[d]) begin
            errors++;
            $display("FAIL err_flag d%0d got %b want %b", d, err[d], exp_err[d]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int d = 0; d < ND; d++) begin
            rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; din[d] = '0; din_m[d] = '0;
            last_dout[d] = 16'h0; exp_err[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            checks++;
            if ({ack[d], dok[d], rdy[d], err[d], dout[d]} !== 20'h0) begin
                errors++;
                $display("FAIL reset_state d%0d got ack,dok,rdy,err=%b dout=%h want 0",
                         d, {ack[d], dok[d], rdy[d], err[d]}, dout[d]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int d = 0; d < ND; d++)
            for (int a = 0; a < MA; a++)
                do_txn(d, 1'b0, 1'b1, a, 16'(16'h1000 + a), 2'b00);
    endtask

    task automatic test_read_burst();
        do_txn(0, 1'b1, 1'b0, 'h13, 16'h0, 2'b00);
        checks++;
        if (last_dout[0] !== 16'h1013) begin
            errors++;
            $display("FAIL burst_last_word got %h want 1013", dout[0]);
        end
        do_txn(1, 1'b1, 1'b0, 'h13, 16'h0, 2'b00);
        do_txn(2, 1'b1, 1'b0, 'h13, 16'h0, 2'b00);
    endtask

    task automatic test_write_mask();
        do_txn(0, 1'b0, 1'b1, 5, 16'h1234, 2'b00);
        do_txn(0, 1'b0, 1'b1, 5, 16'hABCD, 2'b10);
        do_txn(0, 1'b1, 1'b0, 5, 16'h0, 2'b00);
        checks++;
        if (dout[0] !== 16'h1007 || shadow[0][5] !== 16'h12CD) begin
            errors++;
            $display("FAIL write_mask got dout=%h shadow=%h want 1007 12CD", dout[0], shadow[0][5]);
        end
        do_txn(2, 1'b0, 1'b1, 9, 16'h5A5A, 2'b01);
        do_txn(2, 1'b1, 1'b0, 9, 16'h0, 2'b00);
    endtask

    task automatic test_back_to_back();
        int prev;
        for (int d = 0; d < ND; d++) begin
            do_txn(d, 1'b1, 1'b0, 'h13, 16'h0, 2'b00);
            prev = rdy_cyc[d];
            do_txn(d, 1'b1, 1'b0, 'h26, 16'h0, 2'b00);
`ifndef JTFRAME_BA_RESP_STALL_EN
            checks++;
            if (ack_cyc[d] - prev != 2) begin
                errors++;
                $display("FAIL b2b_gap d%0d got %0d want 2", d, ack_cyc[d] - prev);
            end
`endif
        end
    endtask

    task automatic test_err();
        do_txn(0, 1'b1, 1'b1, 7, 16'hBEEF, 2'b00);
        do_txn(0, 1'b1, 1'b0, 4, 16'h0, 2'b00);
        checks++;
        if (last_dout[0] !== 16'hBEEF) begin
            errors++;
            $display("FAIL err_write_data got %h want BEEF", last_dout[0]);
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        rd[0] = 1'b1; addr[0] = 22'h13;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (ack[0]) begin got = 1'b1; break; end
        end
        rd[0] = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL mid_ack_timeout got no ack want ack");
        end
        repeat (lat_of(0) + 1) @(posedge clk);
        #1;
        checks++;
        if (dok[0] !== 1'b1 || dout[0] !== shadow[0][5'h11] || err[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_word1 got dok=%b dout=%h err=%b want 1 %h 1",
                     dok[0], dout[0], err[0], shadow[0][5'h11]);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int d = 0; d < ND; d++) begin
            checks++;
            if ({ack[d], dok[d], rdy[d], err[d], dout[d]} !== 20'h0) begin
                errors++;
                $display("FAIL mid_reset d%0d got ack,dok,rdy,err=%b dout=%h want 0",
                         d, {ack[d], dok[d], rdy[d], err[d]}, dout[d]);
            end
            last_dout[d] = 16'h0;
            exp_err[d] = 1'b0;
        end
        do_txn(0, 1'b1, 1'b0, 'h20, 16'h0, 2'b00);
    endtask

    task automatic test_random();
        int n;
        int d;
        bit is_w;
`ifdef JTFRAME_BA_RESP_STALL_EN
        n = 1000;
`else
        n = 300;
`endif
        for (int i = 0; i < n; i++) begin
            d = $urandom_range(0, ND - 1);
            is_w = ($urandom_range(0, 9) < 4);
            do_txn(d, !is_w, is_w, $urandom_range(0, MA - 1), 16'($urandom),
                   2'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_read_burst();
        test_write_mask();
        test_back_to_back();
        test_err();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
